if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of fetch addresses and instruction words.
REQ-002 Parameter DEPTH, default 2, number of entries in the fetched-instruction queue (power of two, >=2).
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 pc_i  in  PC_WIDTH  fetch address from the PC stage.
REQ-006 pc_valid_i  in  1  pc_i holds a fetch address to be consumed.
REQ-007 pc_ready_o  out  1  block accepts pc_i this cycle.
REQ-008 flush_i  in  1  discard all queued and in-flight fetches.
REQ-009 imem_req_o  out  1  instruction memory request.
REQ-010 imem_addr_o  out  PC_WIDTH  request address.
REQ-011 imem_gnt_i  in  1  memory accepted the request.
REQ-012 imem_rvalid_i  in  1  response data valid.
REQ-013 imem_rdata_i  in  PC_WIDTH  response instruction word.
REQ-014 instr_valid_o  out  1  queue head valid toward decode.
REQ-015 instr_o  out  PC_WIDTH  head instruction word.
REQ-016 instr_pc_o  out  PC_WIDTH  address the head instruction was fetched from.
REQ-017 instr_fault_o  out  1  head entry is a misaligned-fetch fault.
REQ-018 instr_ready_i  in  1  decode consumes the head this cycle.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one memory request outstanding.
REQ-020 pc_ready_o SHALL be 1 iff state==IDLE, flush_i==0, and (queue count + (state!=IDLE)) < DEPTH.
REQ-021 Handshake on pc_valid_i & pc_ready_o with pc_i[1:0]==0: latch pc_i into the address register; next state REQ.
REQ-022 Handshake with pc_i[1:0]!=0: no memory request; push entry {instr=0x00000013, pc=pc_i, fault=1}; stay IDLE.
REQ-023 In REQ: imem_req_o=1; imem_addr_o=latched address, stable until granted; imem_gnt_i -> WAIT.
REQ-024 In WAIT: imem_rvalid_i -> push {imem_rdata_i, latched address, fault=0}; next state IDLE.
REQ-025 imem_rvalid_i SHALL be ignored in IDLE and REQ; response arrives no earlier than the cycle after grant.
REQ-026 imem_req_o SHALL be 0 in IDLE, WAIT, DROP.
REQ-027 Queue pops when instr_valid_o & instr_ready_i; simultaneous push and pop SHALL leave count unchanged, order preserved (FIFO).
REQ-028 instr_valid_o = (count!=0); instr_o, instr_pc_o, instr_fault_o SHALL be the head entry, all 0 when empty.
REQ-029 Push and pop latency: a pushed entry appears on outputs the cycle after the push edge; no combinational path imem_rdata_i -> instr_o.
REQ-030 Reservation (REQ-020) guarantees no push while full; push-when-full SHALL never occur.
REQ-031 flush_i SHALL clear the queue (count=0) at the next edge, overriding any same-cycle push or pop.
REQ-032 flush_i in IDLE: state stays IDLE. In REQ: request held until imem_gnt_i, then DROP (REQ -> DROP directly if gnt same cycle as flush). In WAIT: -> DROP, unless imem_rvalid_i same cycle -> IDLE with data discarded.
REQ-033 In DROP: imem_rvalid_i -> IDLE, data discarded; flush_i in DROP has no further effect.
REQ-034 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.

Reset
REQ-035 rst_i high at an edge SHALL set state=IDLE, count=0, pointers=0, all queue storage and address register=0.
REQ-036 During and after reset: imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, instr_fault_o=0, pc_ready_o=0 while rst_i high.
REQ-037 Reset mid-transaction (REQ/WAIT/DROP) SHALL abandon the request; a late imem_rvalid_i after reset SHALL be ignored.

Verification
REQ-038 Basic fetch: pc_i=0xBFC00000, gnt next cycle, rvalid one cycle later with 0x00500093 -> instr_valid_o=1, instr_o=0x00500093, instr_pc_o=0xBFC00000, fault=0.
REQ-039 Backpressure: instr_ready_i=0, fetch 0xBFC00000 and 0xBFC00004 -> count=2, pc_ready_o=0; one pop -> pc_ready_o=1, order preserved.
REQ-040 Misaligned: pc_i=0xBFC00002 -> no imem_req_o, entry {0x00000013, 0xBFC00002, fault=1}.
REQ-041 Flush in WAIT: flush_i pulse before rvalid -> DROP, response 0xDEADBEEF discarded, instr_valid_o stays 0, next pc accepted after return to IDLE.
REQ-042 Flush in REQ with gnt delayed 3 cycles -> imem_req_o and imem_addr_o held stable until gnt, then DROP; queue empty.
REQ-043 Reset in WAIT then rvalid -> nothing pushed, all outputs 0.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: takes fetch addresses from the PC stage, issues one
// instruction-memory request at a time, and queues responses (or misalignment faults) for decode.
module if_fetch #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                pc_valid_i,
  output logic                pc_ready_o,
  input  logic                flush_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_gnt_i,
  input  logic                imem_rvalid_i,
  input  logic [PC_WIDTH-1:0] imem_rdata_i,
  output logic                instr_valid_o,
  output logic [PC_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0] instr_pc_o,
  output logic                instr_fault_o,
  input  logic                instr_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]    FULL = CNT_W'(DEPTH);
  localparam logic [PC_WIDTH-1:0] NOP  = PC_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t              state;
  logic                drop_pend;
  logic [PC_WIDTH-1:0] addr_q;
  logic [PC_WIDTH-1:0] q_instr [DEPTH];
  logic [PC_WIDTH-1:0] q_pc    [DEPTH];
  logic [DEPTH-1:0]    q_fault;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                accept;
  logic                misaligned;
  logic                rsp_push;
  logic                push;
  logic                pop;
  logic                head_vld;
  logic [PC_WIDTH-1:0] push_instr;
  logic [PC_WIDTH-1:0] push_pc;

  // Only IDLE accepts, so the slot reserved for an outstanding fetch is implied by state.
  assign pc_ready_o = !rst_i && (state == IDLE) && !flush_i && (count < FULL);
  assign accept     = pc_valid_i && pc_ready_o;
  assign misaligned = accept && (pc_i[1:0] != 2'b00);
  assign rsp_push   = (state == WAIT) && imem_rvalid_i && !flush_i;
  assign push       = misaligned || rsp_push;
  assign push_instr = misaligned ? NOP : imem_rdata_i;
  assign push_pc    = misaligned ? pc_i : addr_q;

  assign head_vld      = !rst_i && (count != '0);
  assign pop           = head_vld && instr_ready_i;
  assign instr_valid_o = head_vld;
  assign instr_o       = head_vld ? q_instr[rd_ptr] : '0;
  assign instr_pc_o    = head_vld ? q_pc[rd_ptr]    : '0;
  assign instr_fault_o = head_vld && q_fault[rd_ptr];

  assign imem_req_o  = !rst_i && (state == REQ);
  assign imem_addr_o = addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      drop_pend <= 1'b0;
      addr_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      q_fault   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= push_instr;
          q_pc[wr_ptr]    <= push_pc;
          q_fault[wr_ptr] <= misaligned;
          wr_ptr          <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (accept && !misaligned) begin
            addr_q    <= pc_i;
            drop_pend <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          // A flushed request must still complete its grant; remember to drop its response.
          if (imem_gnt_i)   state <= (flush_i || drop_pend) ? DROP : WAIT;
          else if (flush_i) drop_pend <= 1'b1;
        end
        WAIT: begin
          if (imem_rvalid_i) state <= IDLE;
          else if (flush_i)  state <= DROP;
        end
        DROP: begin
          if (imem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a transaction-level model predicts queued entries,
// a separate monitor compares every entry decode consumes.
module tb_if_fetch;
  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_i, pc_valid_i, pc_ready_o, flush_i;
  logic [W-1:0] pc_i, imem_addr_o, imem_rdata_i, instr_o, instr_pc_o;
  logic         imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic         instr_valid_o, instr_fault_o, instr_ready_i;

  always #5 clk = ~clk;

  if_fetch #(.PC_WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
    .pc_ready_o(pc_ready_o), .flush_i(flush_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_fault_o(instr_fault_o), .instr_ready_i(instr_ready_i)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          vis_cnt = 0;
  bit          m_busy = 0, m_gnt = 0, m_drop = 0;
  logic [31:0] m_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check and update the model, wait for next fall.
  task automatic step(input bit rst, input bit pv, input logic [31:0] pc, input bit fl,
                      input bit rdy, input bit gnt, input bit rv, input logic [31:0] data,
                      input bit stray);
    bit m_ready;
    rst_i         = rst;
    pc_valid_i    = pv;
    pc_i          = pc;
    flush_i       = fl;
    instr_ready_i = rdy;
    imem_gnt_i    = gnt;
    imem_rvalid_i = (rv && m_gnt) || stray;
    imem_rdata_i  = data;
    #2;
    if (rst) begin
      chk("rst_pc_ready", {31'b0, pc_ready_o}, 0);
      chk("rst_imem_req", {31'b0, imem_req_o}, 0);
      chk("rst_instr_valid", {31'b0, instr_valid_o}, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_instr_pc", instr_pc_o, 0);
      chk("rst_fault", {31'b0, instr_fault_o}, 0);
      exp_q.delete();
      vis_cnt = 0;
      m_busy = 0;
      m_gnt = 0;
      m_drop = 0;
    end else begin
      vis_cnt = exp_q.size();
      m_ready = !fl && !m_busy && (exp_q.size() < D);
      chk("pc_ready", {31'b0, pc_ready_o}, {31'b0, m_ready});
      chk("imem_req", {31'b0, imem_req_o}, {31'b0, m_busy && !m_gnt});
      if (m_busy && !m_gnt) chk("imem_addr", imem_addr_o, m_pc);
      if (fl) begin
        exp_q.delete();
        if (m_busy) m_drop = 1;
      end
      if (m_gnt && imem_rvalid_i) begin
        if (!m_drop && !fl) exp_q.push_back('{data, m_pc, 1'b0});
        m_busy = 0;
        m_gnt  = 0;
      end else if (m_busy && !m_gnt && gnt) begin
        m_gnt = 1;
      end else if (pv && m_ready) begin
        if (pc[1:0] != 2'b00) exp_q.push_back('{32'h0000_0013, pc, 1'b1});
        else begin
          m_busy = 1;
          m_gnt  = 0;
          m_drop = 0;
          m_pc   = pc;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, rdy, 0, 0, 0, 0);
  endtask

  // Monitor: compares the head entry whenever decode consumes it.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_i) begin
        chk("instr_valid", {31'b0, instr_valid_o}, {31'b0, vis_cnt != 0});
        if (!instr_valid_o) begin
          chk("empty_instr", instr_o, 0);
          chk("empty_pc", instr_pc_o, 0);
          chk("empty_fault", {31'b0, instr_fault_o}, 0);
        end else if (instr_ready_i && !flush_i) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pop_unexpected: actual=%h required=none", instr_o);
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr_o, e.instr);
            chk("instr_pc", instr_pc_o, e.pc);
            chk("instr_fault", {31'b0, instr_fault_o}, {31'b0, e.fault});
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1; pc_valid_i = 0; pc_i = 0; flush_i = 0; instr_ready_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    @(negedge clk);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic fetch
    step(0, 1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h0050_0093, 0);
    idle(1);
    idle(1);

    // Backpressure: two entries fill the queue, one pop frees a slot
    step(0, 1, 32'hBFC0_0000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111, 0);
    step(0, 1, 32'hBFC0_0004, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222, 0);
    step(0, 1, 32'hBFC0_0008, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hBFC0_0008, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    idle(1);

    // Misaligned fetch
    step(0, 1, 32'hBFC0_0002, 0, 0, 1, 0, 0, 0);
    idle(0);
    idle(1);
    idle(1);

    // Flush in WAIT drops the response; next pc accepted afterwards
    step(0, 1, 32'hBFC0_0010, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 32'hBFC0_0020, 0, 1, 0, 1, 32'hDEAD_BEEF, 0);
    idle(1);
    step(0, 1, 32'hBFC0_0020, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 32'hCAFE_0001, 0);
    idle(1);
    idle(1);

    // Flush in REQ with grant delayed 3 cycles
    step(0, 1, 32'hBFC0_0030, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 32'h3333_3333, 0);
    idle(1);
    idle(1);

    // Reset in WAIT, then a late response
    step(0, 1, 32'hBFC0_0040, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 32'h4444_4444, 1);
    idle(1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) pc[1:0] = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)), pc,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 0);
    end

    // Drain
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 1, 1, $urandom, 0);
    chk("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
